// File: rtl/gelu_lane_sequencer.sv
// gelu_lane_sequencer: feeds a GELU lane one sample at a time from a local
// buffer, waits (with a timeout) for each result, and hands the results
// downstream over a valid/ready port while counting flagged items.
//
// state | meaning
// IDLE  | buffer writable, waiting for start
// ISSUE | one-cycle issue of buf[idx] to the lane
// WAIT  | waiting for the lane result or the timeout
// EMIT  | result offered downstream until m_ready
// DONE  | one-cycle end-of-run pulse
module gelu_lane_sequencer #(
    parameter int W       = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 60
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   in_wr_addr,
    input  logic [W-1:0]               in_wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    output logic                       lane_valid_in,
    output logic [W-1:0]               lane_xi,
    input  logic                       lane_valid_out,
    input  logic [W-1:0]               lane_result,
    input  logic                       lane_div_by_zero,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [W-1:0]               m_data,
    output logic                       m_div_by_zero,
    output logic                       m_timeout,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  mem_rd;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [TW-1:0] timer;
    logic [W-1:0]  xi_hold;
    logic [W-1:0]  data_q;
    logic          dbz_q;
    logic          to_q;
    logic [7:0]    err_q;
    logic          timed_out;
    logic          last_item;

    assign mem_rd    = mem[idx[AW-1:0]];
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign last_item = (idx == len_q - LW'(1));

    assign m_data        = data_q;
    assign m_div_by_zero = dbz_q;
    assign m_timeout     = to_q;
    assign err_count     = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt     = state;
        lane_valid_in = 1'b0;
        lane_xi       = xi_hold;
        m_valid       = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                lane_valid_in = 1'b1;
                lane_xi       = mem_rd;
                state_nxt     = WAIT;
            end
            WAIT: begin
                // a response arriving on the timeout cycle still wins
                if (lane_valid_out || timed_out) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = last_item ? DONE : ISSUE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run bookkeeping: length, index, timer, captured result and error count
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            idx     <= '0;
            timer   <= '0;
            xi_hold <= '0;
            data_q  <= '0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q <= '0;
                        idx   <= '0;
                        len_q <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                    end
                end
                ISSUE: begin
                    xi_hold <= mem_rd;
                    timer   <= '0;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (lane_valid_out) begin
                        data_q <= lane_result;
                        dbz_q  <= lane_div_by_zero;
                        to_q   <= 1'b0;
                    end else if (timed_out) begin
                        data_q <= '0;
                        dbz_q  <= 1'b0;
                        to_q   <= 1'b1;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if ((dbz_q || to_q) && (err_q != 8'hFF)) begin
                            err_q <= err_q + 8'd1;
                        end
                        if (!last_item) begin
                            idx <= idx + LW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sample buffer: writable only while idle, contents survive reset
    always_ff @(posedge clk) begin
        if (state == IDLE && in_wr_en) begin
            mem[in_wr_addr] <= in_wr_data;
        end
    end
endmodule

// File: tb/tb_gelu_lane_sequencer.sv
// Testbench for gelu_lane_sequencer: lane stand-in model, scoreboard of
// expected issues and results, and one task per scenario.
`timescale 1ns/1ps
module tb_gelu_lane_sequencer;
    localparam int W       = 32;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 60;
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_wr_en = 1'b0;
    logic [AW-1:0] in_wr_addr = '0;
    logic [W-1:0]  in_wr_data = '0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          lane_valid_in;
    logic [W-1:0]  lane_xi;
    logic          lane_valid_out = 1'b0;
    logic [W-1:0]  lane_result = '0;
    logic          lane_div_by_zero = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [W-1:0]  m_data;
    logic          m_div_by_zero;
    logic          m_timeout;
    logic          busy;
    logic          done;
    logic [7:0]    err_count;

    gelu_lane_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .start(start), .len(len),
        .lane_valid_in(lane_valid_in), .lane_xi(lane_xi),
        .lane_valid_out(lane_valid_out), .lane_result(lane_result),
        .lane_div_by_zero(lane_div_by_zero),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_div_by_zero(m_div_by_zero), .m_timeout(m_timeout),
        .busy(busy), .done(done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         dbz;
        logic         to;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] tb_mem [DEPTH];
    logic [W-1:0] exp_xi [$];
    exp_t         exp_m [$];

    int          lane_lat = 5;
    logic [15:0] silent_mask = '0;
    logic [15:0] dbz_mask = '0;
    int          lane_cd = 0;
    int          lane_seq = 0;
    int          lane_item = 0;
    logic [W-1:0] lane_x = '0;
    bit          force_resp = 1'b0;

    int n_issue = 0;
    int n_hs = 0;
    int n_done = 0;
    int hs_cyc = 0;
    int done_cyc = 0;
    int issue_cyc [64];
    int mv_rise [64];
    logic mv_prev = 1'b0;

    function automatic logic [W-1:0] lane_f(input logic [W-1:0] x);
        return {x[W-2:0], 1'b0} ^ 32'h0000_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        in_wr_en   = 1'b1;
        in_wr_addr = AW'(a);
        in_wr_data = d;
        tb_mem[a]  = d;
        tick();
        in_wr_en = 1'b0;
    endtask

    task automatic clear_run();
        n_issue  = 0;
        n_hs     = 0;
        n_done   = 0;
        lane_seq = 0;
    endtask

    task automatic push_run(input int n);
        int k;
        exp_t e;
        k = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < k; i++) begin
            exp_xi.push_back(tb_mem[i]);
            if (silent_mask[i]) e = '{data: '0, dbz: 1'b0, to: 1'b1};
            else                e = '{data: lane_f(tb_mem[i]), dbz: dbz_mask[i], to: 1'b0};
            exp_m.push_back(e);
        end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = LW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tick();
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // lane stand-in: fixed latency, per-item silence and div-by-zero masks
    initial forever begin
        @(negedge clk);
        lane_valid_out   = 1'b0;
        lane_div_by_zero = 1'b0;
        if (force_resp) begin
            lane_valid_out = 1'b1;
            lane_result    = 32'h1111_2222;
            force_resp     = 1'b0;
        end
        if (lane_cd > 0) begin
            lane_cd--;
            if (lane_cd == 0 && lane_item < 16 && !silent_mask[lane_item]) begin
                lane_valid_out   = 1'b1;
                lane_result      = lane_f(lane_x);
                lane_div_by_zero = dbz_mask[lane_item];
            end
        end
        if (lane_valid_in) begin
            lane_x    = lane_xi;
            lane_item = lane_seq;
            lane_seq++;
            lane_cd   = lane_lat;
        end
    end

    // monitor: issue order and downstream results against the scoreboard
    initial forever begin
        logic [W-1:0] ex;
        exp_t em;
        @(negedge clk);
        if (!rst) begin
            if (lane_valid_in) begin
                checks++;
                if (exp_xi.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue: lane_xi=%h with no issue expected", lane_xi);
                end else begin
                    ex = exp_xi.pop_front();
                    if (lane_xi !== ex) begin
                        failures++;
                        $display("FAIL lane_xi item %0d: got %h expected %h", n_issue, lane_xi, ex);
                    end
                end
                if (n_issue < 64) issue_cyc[n_issue] = cyc;
                n_issue++;
            end
            if (m_valid && !mv_prev && n_hs < 64) mv_rise[n_hs] = cyc;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_m.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: m_data=%h with no result expected", m_data);
                end else begin
                    em = exp_m.pop_front();
                    if (m_data !== em.data || m_div_by_zero !== em.dbz || m_timeout !== em.to) begin
                        failures++;
                        $display("FAIL m_result item %0d: got data=%h dbz=%b to=%b expected data=%h dbz=%b to=%b",
                                 n_hs, m_data, m_div_by_zero, m_timeout, em.data, em.dbz, em.to);
                    end
                end
                hs_cyc = cyc;
                n_hs++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        mv_prev = m_valid;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lane_valid_in, m_valid, m_div_by_zero, m_timeout, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {lane_valid_in, m_valid, m_div_by_zero, m_timeout, busy, done});
        end
        checks++;
        if (m_data !== '0 || lane_xi !== '0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got m_data=%h lane_xi=%h err=%0d expected 0", m_data, lane_xi, err_count);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit seen;
        wr(0, 32'h0400_0000);
        wr(1, 32'hFC00_0000);
        wr(2, 32'h0000_0000);
        silent_mask = '0; dbz_mask = '0; lane_lat = 5;
        clear_run();
        push_run(3);
        do_start(3);
        wait_done(300, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL basic_done: got no done expected done within 300"); end
        checks++;
        if (n_issue != 3 || n_hs != 3 || n_done != 1) begin
            failures++;
            $display("FAIL basic_counts: got issues=%0d hs=%0d dones=%0d expected 3 3 1", n_issue, n_hs, n_done);
        end
        checks++;
        if (done_cyc != hs_cyc + 1) begin
            failures++;
            $display("FAIL basic_done_timing: got done at %0d expected %0d", done_cyc, hs_cyc + 1);
        end
        checks++;
        if (err_count !== 8'd0 || exp_m.size() != 0) begin
            failures++;
            $display("FAIL basic_err: got err=%0d pending=%0d expected 0 0", err_count, exp_m.size());
        end
    endtask

    task automatic test_timeout();
        bit seen;
        wr(0, 32'h0123_4567);
        wr(1, 32'h0765_4321);
        wr(2, 32'hF000_0001);
        silent_mask = 16'h0002; dbz_mask = '0; lane_lat = 4;
        clear_run();
        push_run(3);
        do_start(3);
        wait_done(500, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_done: got no done expected done within 500"); end
        checks++;
        if (mv_rise[1] - (issue_cyc[1] + 1) != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", mv_rise[1] - (issue_cyc[1] + 1), TIMEOUT);
        end
        checks++;
        if (n_issue != 3 || n_hs != 3 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL timeout_counts: got issues=%0d hs=%0d err=%0d expected 3 3 1", n_issue, n_hs, err_count);
        end
    endtask

    task automatic test_dbz();
        bit seen;
        silent_mask = '0; dbz_mask = 16'h0001; lane_lat = 2;
        clear_run();
        push_run(2);
        do_start(2);
        wait_done(200, seen);
        checks++;
        if (!seen || n_hs != 2 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL dbz_err: got seen=%b hs=%0d err=%0d expected 1 2 1", seen, n_hs, err_count);
        end
        dbz_mask = '0;
    endtask

    task automatic test_len_zero();
        bit seen;
        clear_run();
        do_start(0);
        wait_done(10, seen);
        checks++;
        if (!seen || n_issue != 0 || n_done != 1 || err_count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len_zero: got seen=%b issues=%0d dones=%0d err=%0d busy=%b expected 1 0 1 0 0",
                     seen, n_issue, n_done, err_count, busy);
        end
    endtask

    task automatic test_stall();
        bit seen;
        logic [W-1:0] d0;
        logic dz0, to0;
        silent_mask = '0; dbz_mask = '0; lane_lat = 3;
        m_ready = 1'b0;
        clear_run();
        push_run(1);
        do_start(1);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL stall_valid: got no m_valid expected m_valid within 100"); end
        d0 = m_data; dz0 = m_div_by_zero; to0 = m_timeout;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== d0 || m_div_by_zero !== dz0 || m_timeout !== to0 || lane_valid_in !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: got v=%b d=%h dz=%b to=%b issue=%b expected 1 %h %b %b 0",
                         k, m_valid, m_data, m_div_by_zero, m_timeout, lane_valid_in, d0, dz0, to0);
            end
        end
        tick();
        m_ready = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen || n_hs != 1 || exp_m.size() != 0) begin
            failures++;
            $display("FAIL stall_release: got seen=%b hs=%0d pending=%0d expected 1 1 0", seen, n_hs, exp_m.size());
        end
    endtask

    task automatic test_busy_ignore();
        bit seen;
        silent_mask = '0; dbz_mask = '0; lane_lat = 8;
        clear_run();
        push_run(2);
        do_start(2);
        for (int k = 0; k < 3; k++) begin
            in_wr_en = 1'b1; in_wr_addr = '0; in_wr_data = 32'hDEAD_BEEF;
            start = 1'b1; len = LW'(5);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL busy_flag: got %b expected 1", busy); end
            tick();
        end
        in_wr_en = 1'b0; start = 1'b0;
        wait_done(300, seen);
        checks++;
        if (!seen || n_issue != 2 || n_done != 1) begin
            failures++;
            $display("FAIL busy_start: got seen=%b issues=%0d dones=%0d expected 1 2 1", seen, n_issue, n_done);
        end
        clear_run();
        push_run(1);
        do_start(1);
        wait_done(100, seen);
        checks++;
        if (!seen || n_hs != 1) begin
            failures++;
            $display("FAIL busy_rerun: got seen=%b hs=%0d expected 1 1", seen, n_hs);
        end
    endtask

    task automatic test_clamp();
        bit seen;
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom() | 32'h1);
        silent_mask = '0; dbz_mask = '0; lane_lat = 1;
        clear_run();
        push_run(20);
        do_start(20);
        wait_done(800, seen);
        checks++;
        if (!seen || n_issue != DEPTH || n_hs != DEPTH || exp_m.size() != 0) begin
            failures++;
            $display("FAIL clamp_len: got seen=%b issues=%0d hs=%0d expected 1 %0d %0d", seen, n_issue, n_hs, DEPTH, DEPTH);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        silent_mask = 16'hFFFF; dbz_mask = '0; lane_lat = 5;
        clear_run();
        push_run(2);
        do_start(2);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (lane_valid_in) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_issue: got no issue expected issue within 20"); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({lane_valid_in, m_valid, m_div_by_zero, m_timeout, busy, done} !== 6'b0 ||
            m_data !== '0 || lane_xi !== '0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got ctrl=%b m_data=%h lane_xi=%h err=%0d expected all 0",
                     {lane_valid_in, m_valid, m_div_by_zero, m_timeout, busy, done}, m_data, lane_xi, err_count);
        end
        tick();
        rst = 1'b0;
        exp_xi.delete();
        exp_m.delete();
        clear_run();
        tick();
        tick();
        force_resp = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || done !== 1'b0 || lane_valid_in !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet cycle %0d: got v=%b done=%b issue=%b busy=%b expected 0 0 0 0",
                         k, m_valid, done, lane_valid_in, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_dbz();
        test_len_zero();
        test_stall();
        test_busy_ignore();
        test_clamp();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gelu_lane_sequencer.md
GELU_LANE_SEQUENCER -- requirements
Module: gelu_lane_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, meaning data width in Q5.26 fixed point.
REQ-002 SHALL have parameter DEPTH, default 16, meaning input buffer entries.
REQ-003 SHALL have parameter TIMEOUT, default 60, meaning maximum wait cycles for a lane response.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port in_wr_en, input, 1, meaning buffer write strobe.
REQ-007 SHALL have port in_wr_addr, input, $clog2(DEPTH), meaning buffer write address.
REQ-008 SHALL have port in_wr_data, input, W, meaning signed xi sample to store.
REQ-009 SHALL have port start, input, 1, meaning begin run.
REQ-010 SHALL have port len, input, $clog2(DEPTH+1), meaning number of samples in the run.
REQ-011 SHALL have port lane_valid_in, output, 1, meaning issue strobe to the GELU lane.
REQ-012 SHALL have port lane_xi, output, W, meaning sample issued to the lane.
REQ-013 SHALL have port lane_valid_out, input, 1, meaning lane result strobe.
REQ-014 SHALL have port lane_result, input, W, meaning lane gelu result.
REQ-015 SHALL have port lane_div_by_zero, input, 1, meaning lane zero-denominator flag.
REQ-016 SHALL have port m_valid, output, 1, meaning a result is offered downstream.
REQ-017 SHALL have port m_ready, input, 1, meaning downstream accepts.
REQ-018 SHALL have port m_data, output, W, meaning result value.
REQ-019 SHALL have port m_div_by_zero, output, 1, meaning the lane flagged this item.
REQ-020 SHALL have port m_timeout, output, 1, meaning the lane did not respond for this item.
REQ-021 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-022 SHALL have port done, output, 1, meaning one-cycle end-of-run pulse.
REQ-023 SHALL have port err_count, output, 8, meaning count of flagged items in the current or last run.

Function
REQ-024 SHALL implement the FSM states IDLE, ISSUE, WAIT, EMIT and DONE.
REQ-025 SHALL write the buffer only in IDLE when in_wr_en is high, ignoring in_wr_en in every other state.
REQ-026 SHALL, in IDLE on start with len greater than 0, latch min(len, DEPTH), clear idx and err_count, and go to ISSUE.
REQ-027 SHALL, on start with len equal to 0, clear err_count, go to DONE, and never assert lane_valid_in.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL, in ISSUE, assert lane_valid_in for exactly one cycle with lane_xi equal to buf[idx], then go to WAIT with timer cleared.
REQ-030 SHALL hold lane_xi at its last issued value when not issuing.
REQ-031 SHALL, in WAIT, increment timer every cycle.
REQ-032 SHALL, in WAIT when lane_valid_out is high, capture lane_result and lane_div_by_zero, clear the timeout flag, and go to EMIT.
REQ-033 SHALL, in WAIT when timer reaches TIMEOUT-1 with lane_valid_out low, set m_data to 0, m_timeout to 1 and m_div_by_zero to 0, and go to EMIT.
REQ-034 SHALL give lane_valid_out priority over the timeout when both occur in the same cycle.
REQ-035 SHALL ignore lane_valid_out outside WAIT, including a late response after a timeout.
REQ-036 SHALL, in EMIT, hold m_valid high with m_data and flags stable until m_ready is high.
REQ-037 SHALL, on the EMIT handshake, increment err_count (saturating at 255) if either flag is set.
REQ-038 SHALL, on the EMIT handshake, go to DONE if idx equals len-1, else increment idx and go to ISSUE.
REQ-039 SHALL keep at most one lane request outstanding at any time.
REQ-040 SHALL, in DONE, assert done for one cycle and return to IDLE.
REQ-041 SHALL give a minimum per-item latency of ISSUE 1 cycle, plus lane latency, plus EMIT at least 1 cycle.

Reset
REQ-042 SHALL, on rst high at a clock edge, enter IDLE and drive lane_valid_in, m_valid, m_data, m_div_by_zero, m_timeout, busy, done, err_count, lane_xi, idx and timer to 0.
REQ-043 SHALL leave buffer contents unreset.
REQ-044 SHALL, on reset mid-run, abandon the run with no done pulse and ignore any later lane_valid_out.

Verification
REQ-045 SHALL cover: write 0x04000000, 0xFC000000, 0x00000000; start len=3 with a lane model of latency 5 -> exactly 3 lane_valid_in pulses with lane_xi in that order, 3 in-order m handshakes, done one cycle after the third handshake, err_count=0.
REQ-046 SHALL cover: lane model silent for item 1 -> m_valid rises 60 cycles after WAIT entry with m_data=0 and m_timeout=1, item 2 still issued, err_count=1 at done.
REQ-047 SHALL cover: lane returns div_by_zero=1 for item 0 -> m_div_by_zero=1, err_count=1.
REQ-048 SHALL cover: m_ready held low for 20 cycles in EMIT -> m_valid, m_data and flags stable, no lane_valid_in.
REQ-049 SHALL cover: start with len=0 -> done pulse, zero lane_valid_in; start and in_wr_en while busy -> no effect.
REQ-050 SHALL cover: rst asserted mid-WAIT -> all outputs 0 next cycle; lane_valid_out 2 cycles later -> no m_valid and no done.
